ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/ldm_stm_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// Load/Store Multiple sequencer: walks an ARM-style register list, issuing one
// word transfer per set bit at ascending addresses, then optionally writes back Rn.
module ldm_stm_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [31:0] IR,
    input  logic [31:0] BASE,
    input  logic        ACK,
    output logic        BUSY,
    output logic        MEM_REQ,
    output logic        RW,
    output logic [31:0] ADDR,
    output logic [3:0]  REG_SEL,
    output logic        WB_EN,
    output logic [31:0] WB_VALUE,
    output logic        DONE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_XFER   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_list;
    logic        r_p;
    logic        r_u;
    logic        r_w;
    logic        r_l;
    logic        r_nonempty;
    logic [31:0] r_base;
    logic [31:0] r_addr;
    logic [3:0]  r_reg_sel;
    logic [31:0] r_wb_value;

    logic [4:0]  w_count;
    logic [31:0] w_offset;
    logic [31:0] w_start_addr;
    logic [15:0] w_list_cleared;
    logic [3:0]  w_first_idx;
    logic [3:0]  w_next_idx;
    logic        w_unused;

    // Only P, U, W, L and the register list matter to this block.
    assign w_unused = ^{IR[31:25], IR[22], IR[19:16]};

    always_comb begin
        w_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + {4'd0, r_list[i]};
        end
    end

    assign w_offset = {25'd0, w_count, 2'b00};

    always_comb begin
        w_start_addr = r_base;
        case ({r_p, r_u})
            2'b01:   w_start_addr = r_base;
            2'b11:   w_start_addr = r_base + 32'd4;
            2'b00:   w_start_addr = r_base - w_offset + 32'd4;
            default: w_start_addr = r_base - w_offset;
        endcase
    end

    assign w_list_cleared = r_list & ~(16'd1 << r_reg_sel);

    // Scanning high-to-low leaves the lowest set index as the final winner.
    always_comb begin
        w_first_idx = 4'd0;
        w_next_idx  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_first_idx = 4'(i);
            end
            if (w_list_cleared[i]) begin
                w_next_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSY         = 1'b1;
        MEM_REQ      = 1'b0;
        WB_EN        = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = (w_count != 5'd0) ? S_XFER : S_FINISH;
            end
            S_XFER: begin
                MEM_REQ = 1'b1;
                if (ACK && (w_list_cleared == 16'd0)) begin
                    w_state_next = S_FINISH;
                end
            end
            default: begin
                DONE         = 1'b1;
                WB_EN        = r_w & r_nonempty;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_list     <= 16'd0;
            r_p        <= 1'b0;
            r_u        <= 1'b0;
            r_w        <= 1'b0;
            r_l        <= 1'b0;
            r_nonempty <= 1'b0;
            r_base     <= 32'd0;
            r_addr     <= 32'd0;
            r_reg_sel  <= 4'd0;
            r_wb_value <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_list <= IR[15:0];
                        r_p    <= IR[24];
                        r_u    <= IR[23];
                        r_w    <= IR[21];
                        r_l    <= IR[20];
                        r_base <= BASE;
                    end
                end
                S_CALC: begin
                    r_nonempty <= (w_count != 5'd0);
                    r_wb_value <= r_u ? (r_base + w_offset) : (r_base - w_offset);
                    // An empty list never transfers, so leave ADDR/REG_SEL untouched.
                    if (w_count != 5'd0) begin
                        r_addr    <= w_start_addr;
                        r_reg_sel <= w_first_idx;
                    end
                end
                S_XFER: begin
                    if (ACK) begin
                        r_list    <= w_list_cleared;
                        r_addr    <= r_addr + 32'd4;
                        r_reg_sel <= w_next_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign RW       = r_l;
    assign ADDR     = r_addr;
    assign REG_SEL  = r_reg_sel;
    assign WB_VALUE = r_wb_value;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed cases plus random operations, each
// checked cycle-by-cycle against a transfer list built from the LDM/STM rules.
`timescale 1ns/1ps
module tb_ldm_stm_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [31:0] IR;
    logic [31:0] BASE;
    logic        ACK;
    logic        BUSY;
    logic        MEM_REQ;
    logic        RW;
    logic [31:0] ADDR;
    logic [3:0]  REG_SEL;
    logic        WB_EN;
    logic [31:0] WB_VALUE;
    logic        DONE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ldm_stm_sequencer dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .IR       (IR),
        .BASE     (BASE),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .MEM_REQ  (MEM_REQ),
        .RW       (RW),
        .ADDR     (ADDR),
        .REG_SEL  (REG_SEL),
        .WB_EN    (WB_EN),
        .WB_VALUE (WB_VALUE),
        .DONE     (DONE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic p, input logic u, input logic w,
                                          input logic l, input logic [15:0] list);
        logic [31:0] junk;
        junk = $urandom;
        // Bits outside P/U/W/L/list are randomised to show they are ignored.
        return {junk[31:25], p, u, junk[22], w, l, junk[19:16], list};
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_memreq"}, {31'd0, MEM_REQ}, 32'd0);
        check({tag, "_rw"}, {31'd0, RW}, 32'd0);
        check({tag, "_addr"}, ADDR, 32'd0);
        check({tag, "_regsel"}, {28'd0, REG_SEL}, 32'd0);
        check({tag, "_wbvalue"}, WB_VALUE, 32'd0);
        check({tag, "_wben"}, {31'd0, WB_EN}, 32'd0);
        check({tag, "_done"}, {31'd0, DONE}, 32'd0);
    endtask

    // Runs one LDM/STM; ack_delay<0 picks a random 0..3 wait per transfer.
    task automatic run_op(input string tag, input logic p, input logic u, input logic w,
                          input logic l, input logic [15:0] list, input logic [31:0] base,
                          input int ack_delay, input bit noise);
        logic [31:0] exp_addr[$];
        int          exp_reg[$];
        int          n;
        logic [31:0] a;
        logic [31:0] wb;
        int          d;
        n = 0;
        for (int i = 0; i < 16; i++) n += list[i] ? 1 : 0;
        case ({p, u})
            2'b01:   a = base;
            2'b11:   a = base + 32'd4;
            2'b00:   a = base - 32'(4 * n) + 32'd4;
            default: a = base - 32'(4 * n);
        endcase
        wb = u ? base + 32'(4 * n) : base - 32'(4 * n);
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_addr.push_back(a);
                exp_reg.push_back(i);
                a = a + 32'd4;
            end
        end

        @(negedge CLK);
        START = 1'b1;
        IR    = mk_ir(p, u, w, l, list);
        BASE  = base;
        ACK   = noise ? 1'($urandom) : 1'b0;
        @(negedge CLK);
        check({tag, "_calc_busy"}, {31'd0, BUSY}, 32'd1);
        check({tag, "_calc_memreq"}, {31'd0, MEM_REQ}, 32'd0);
        check({tag, "_calc_done"}, {31'd0, DONE}, 32'd0);
        START = noise ? 1'($urandom) : 1'b0;
        IR    = $urandom;
        BASE  = $urandom;
        ACK   = noise ? 1'($urandom) : 1'b0;

        for (int k = 0; k < exp_addr.size(); k++) begin
            d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            for (int j = 0; j <= d; j++) begin
                @(negedge CLK);
                check($sformatf("%s_x%0d_memreq", tag, k), {31'd0, MEM_REQ}, 32'd1);
                check($sformatf("%s_x%0d_addr", tag, k), ADDR, exp_addr[k]);
                check($sformatf("%s_x%0d_regsel", tag, k), {28'd0, REG_SEL}, 32'(exp_reg[k]));
                check($sformatf("%s_x%0d_rw", tag, k), {31'd0, RW}, {31'd0, l});
                check($sformatf("%s_x%0d_done", tag, k), {31'd0, DONE}, 32'd0);
                check($sformatf("%s_x%0d_wben", tag, k), {31'd0, WB_EN}, 32'd0);
                ACK   = (j == d);
                START = noise ? 1'($urandom) : 1'b0;
            end
        end

        @(negedge CLK);
        check({tag, "_fin_done"}, {31'd0, DONE}, 32'd1);
        check({tag, "_fin_memreq"}, {31'd0, MEM_REQ}, 32'd0);
        check({tag, "_fin_wben"}, {31'd0, WB_EN}, {31'd0, (w && n > 0)});
        if (w && n > 0) check({tag, "_fin_wbvalue"}, WB_VALUE, wb);
        START = 1'b0;
        ACK   = noise ? 1'($urandom) : 1'b0;
        @(negedge CLK);
        check({tag, "_idle_done"}, {31'd0, DONE}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_idle_wben"}, {31'd0, WB_EN}, 32'd0);
        ACK = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        IR    = 32'd0;
        BASE  = 32'd0;
        ACK   = 1'b0;
        repeat (3) @(negedge CLK);
        check_idle_reset("reset");
        START = 1'b1;
        IR    = mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF);
        @(negedge CLK);
        check("reset_start_ignored", {31'd0, BUSY}, 32'd0);
        START = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);

        run_op("ia4", 1'b0, 1'b1, 1'b0, 1'b1, 16'h000F, 32'h0000_0100, 0, 1'b0);
        run_op("db_wb", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0022, 32'h0000_0200, 0, 1'b0);
        run_op("empty", 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h0000_1000, 0, 1'b1);
        run_op("ackdly", 1'b0, 1'b1, 1'b0, 1'b1, 16'h8001, 32'h0000_3000, 3, 1'b0);

        // Reset while the second of four transfers is pending.
        @(negedge CLK);
        START = 1'b1;
        IR    = mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 16'h0F00);
        BASE  = 32'h0000_0500;
        ACK   = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("rst_mid_first_addr", ADDR, 32'h0000_0500);
        @(negedge CLK);
        check("rst_mid_second_addr", ADDR, 32'h0000_0504);
        check("rst_mid_second_reg", {28'd0, REG_SEL}, 32'd9);
        RST_N = 1'b0;
        @(negedge CLK);
        check_idle_reset("rst_mid");
        RST_N = 1'b1;
        ACK   = 1'b0;
        @(negedge CLK);
        check("rst_mid_no_done", {31'd0, DONE}, 32'd0);
        check("rst_mid_no_wben", {31'd0, WB_EN}, 32'd0);
        run_op("after_rst", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F00, 32'h0000_0500, 0, 1'b0);

        run_op("da_full", 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 32'h0000_0040, 0, 1'b1);
        run_op("db_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 32'h0000_0000, 0, 1'b1);
        run_op("ia_wrap", 1'b1, 1'b1, 1'b1, 1'b1, 16'h8421, 32'hFFFF_FFF8, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] lst;
            lst = (t % 3 == 0) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
            if (t % 10 == 5) lst = 16'd0;
            run_op($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), lst, {$urandom} & 32'hFFFF_FFFC, -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
